// File: rtl/wb_memory_probe_pkg.sv
// Shared types for the Wishbone memory probe: state encodings and command codes.
package memory_probe_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RD   = 2'd1;
    localparam state_t ST_WR   = 2'd2;
    localparam state_t ST_GAP  = 2'd3;

    typedef enum logic [1:0] {
        CMD_LATCH_ADDR = 2'b00,
        CMD_READ       = 2'b01,
        CMD_WRITE      = 2'b10,
        CMD_FILL       = 2'b11
    } cmd_t;

endpackage

// File: rtl/wb_memory_probe_if.sv
// Wishbone classic bus bundle between the probe (master) and the memory (slave).
interface wb_memory_probe_if #(
    parameter int DW = 16,
    parameter int AW = 15
);
    logic            ack_i;
    logic [DW-1:0]   dat_i;
    logic            we_o;
    logic            stb_o;
    logic            cyc_o;
    logic [DW/8-1:0] sel_o;
    logic [AW-1:0]   adr_o;
    logic [DW-1:0]   dat_o;

    modport master (
        input  ack_i, dat_i,
        output we_o, stb_o, cyc_o, sel_o, adr_o, dat_o
    );

    modport slave (
        output ack_i, dat_i,
        input  we_o, stb_o, cyc_o, sel_o, adr_o, dat_o
    );
endinterface

// File: rtl/wb_memory_probe_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous button, emitting a one-cycle pulse per rising edge.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);
    logic [STAGES-1:0] sync_r;
    logic              sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
            sync_q <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], level};
            sync_q <= sync_r[STAGES-1];
        end
    end

    assign pulse = sync_r[STAGES-1] & ~sync_q;
endmodule

// File: rtl/wb_memory_probe.sv
// Button-driven Wishbone classic master for memory bring-up: latch address, read, write, burst fill.
module wb_memory_probe
    import memory_probe_pkg::*;
#(
    parameter int DW          = 16,
    parameter int AW          = 15,
    parameter int FILL_LEN    = 8,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          action_i,
    input  logic [1:0]    cmd_i,
    input  logic          auto_inc_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic [1:0]    state_o,
    output logic          busy_o,
    output logic          err_o,
    wb_memory_probe_if.master wb
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(FILL_LEN + 1);

    state_t          state;
    logic            go;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
    logic [CW-1:0]   wait_cnt;
    logic [BW-1:0]   beats_left;
    logic            fill;
    logic            in_xfer;
    logic            ack;
    logic            expire;
    logic            more_beats;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk_i),
        .rst   (rst_i),
        .level (action_i),
        .pulse (go)
    );

    assign in_xfer    = (state == ST_RD) || (state == ST_WR);
    assign ack        = in_xfer && wb.ack_i;
    // A late ack on the final wait cycle still completes the transfer normally.
    assign expire     = in_xfer && !wb.ack_i && (wait_cnt == CW'(TIMEOUT - 1));
    assign more_beats = fill && (beats_left != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (go) begin
                    case (cmd_t'(cmd_i))
                        CMD_READ:              state <= ST_RD;
                        CMD_WRITE, CMD_FILL:   state <= ST_WR;
                        default:               state <= ST_IDLE;
                    endcase
                end
                ST_RD:   if (ack || expire) state <= ST_IDLE;
                ST_WR: begin
                    if (ack)         state <= more_beats ? ST_GAP : ST_IDLE;
                    else if (expire) state <= ST_IDLE;
                end
                default: state <= ST_WR;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o     <= '0;
            adr        <= '0;
            dat        <= '0;
            err_o      <= 1'b0;
            wait_cnt   <= '0;
            beats_left <= '0;
            fill       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (go) begin
                        err_o <= 1'b0;
                        case (cmd_t'(cmd_i))
                            CMD_LATCH_ADDR: begin
                                adr    <= data_i[AW-1:0];
                                data_o <= data_i;
                            end
                            CMD_WRITE: dat <= data_i;
                            CMD_FILL: begin
                                dat        <= data_i;
                                beats_left <= BW'(FILL_LEN - 1);
                                fill       <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RD, ST_WR: begin
                    if (ack) begin
                        if (state == ST_RD) begin
                            data_o <= wb.dat_i;
                            if (auto_inc_i) adr <= adr + AW'(1);
                        end else begin
                            data_o <= dat;
                            if (more_beats) begin
                                adr        <= adr + AW'(1);
                                dat        <= dat + DW'(1);
                                beats_left <= beats_left - BW'(1);
                            end else begin
                                if (auto_inc_i) adr <= adr + AW'(1);
                                fill <= 1'b0;
                            end
                        end
                    end else if (expire) begin
                        err_o <= 1'b1;
                        fill  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: wait_cnt <= '0;
            endcase
        end
    end

    assign wb.cyc_o = (state != ST_IDLE);
    assign wb.stb_o = in_xfer;
    assign wb.we_o  = (state == ST_WR) || (state == ST_GAP);
    assign wb.sel_o = '1;
    assign wb.adr_o = adr;
    assign wb.dat_o = dat;
    assign state_o  = state;
    assign busy_o   = (state != ST_IDLE);
endmodule
